// File: rtl/keypad_scan_buf.sv
// Matrix keypad scanner with debounce and a first-word-fall-through key FIFO.
// One column is driven low at a time; an accepted press yields one code (row*COLS + col).
module keypad_scan_buf #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SETTLE   = 2,
  parameter int DEBOUNCE = 10,
  parameter int DEPTH    = 4
) (
  input  logic                            clk,
  input  logic                            nRST,
  input  logic [ROWS-1:0]                 row_in,
  output logic [COLS-1:0]                 col_out,
  output logic                            key_rdy,
  input  logic                            key_rd,
  output logic [$clog2(ROWS*COLS)-1:0]    key_code,
  output logic [$clog2(DEPTH):0]          fifo_count,
  output logic                            overflow,
  input  logic                            ovf_clr
);

  localparam int CW  = $clog2(ROWS*COLS);
  localparam int CIW = $clog2(COLS);
  localparam int RW  = $clog2(ROWS);
  localparam int SW  = $clog2(SETTLE+1);
  localparam int PW  = $clog2(DEPTH);
  localparam int NW  = PW + 1;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PUSH     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  state_t          r_state, w_state_next;
  logic [CIW-1:0]  r_col_idx, w_col_next, w_col_inc;
  logic [SW-1:0]   r_settle, w_settle_next;
  logic [7:0]      r_db_cnt, w_db_next;
  logic [ROWS-1:0] r_pat, w_pat_next;
  logic [ROWS-1:0] r_row_s1, r_row_s2;
  logic [RW-1:0]   w_row_sel;
  logic [CW-1:0]   w_code;

  logic [CW-1:0]   r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [NW-1:0]   r_count;
  logic            r_overflow;
  logic            w_push, w_pop, w_wr_en, w_drop;

  // Active-low column drive: only the selected column is pulled to 0.
  for (genvar gi = 0; gi < COLS; gi++) begin : g_col
    assign col_out[gi] = (r_col_idx != CIW'(gi));
  end

  assign w_col_inc = (r_col_idx == CIW'(COLS-1)) ? '0 : r_col_idx + 1'b1;

  always_comb begin
    w_row_sel = '0;
    for (int i = ROWS-1; i >= 0; i--) begin
      if (!r_pat[i]) w_row_sel = RW'(i);
    end
    w_code = CW'(int'(w_row_sel) * COLS + int'(r_col_idx));
  end

  always_comb begin
    w_state_next  = r_state;
    w_col_next    = r_col_idx;
    w_settle_next = r_settle;
    w_db_next     = r_db_cnt;
    w_pat_next    = r_pat;
    case (r_state)
      ST_SCAN: begin
        if (r_settle == SW'(SETTLE)) begin
          w_settle_next = '0;
          if (!(&r_row_s2)) begin
            w_state_next = ST_DEBOUNCE;
            w_pat_next   = r_row_s2;
            w_db_next    = '0;
          end else begin
            w_col_next = w_col_inc;
          end
        end else begin
          w_settle_next = r_settle + 1'b1;
        end
      end
      ST_DEBOUNCE: begin
        if (r_row_s2 == r_pat) begin
          if (r_db_cnt == 8'(DEBOUNCE-1)) begin
            w_state_next = ST_PUSH;
            w_db_next    = '0;
          end else begin
            w_db_next = r_db_cnt + 1'b1;
          end
        end else begin
          w_state_next  = ST_SCAN;
          w_db_next     = '0;
          w_settle_next = '0;
        end
      end
      ST_PUSH: begin
        w_state_next = ST_RELEASE;
        w_db_next    = '0;
      end
      ST_RELEASE: begin
        // Column stays put until the key has been fully released, so a held key never repeats.
        if (&r_row_s2) begin
          if (r_db_cnt == 8'(DEBOUNCE-1)) begin
            w_state_next  = ST_SCAN;
            w_col_next    = w_col_inc;
            w_db_next     = '0;
            w_settle_next = '0;
          end else begin
            w_db_next = r_db_cnt + 1'b1;
          end
        end else begin
          w_db_next = '0;
        end
      end
      default: w_state_next = ST_SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state   <= ST_SCAN;
      r_col_idx <= '0;
      r_settle  <= '0;
      r_db_cnt  <= '0;
      r_pat     <= '1;
      r_row_s1  <= '1;
      r_row_s2  <= '1;
    end else begin
      r_state   <= w_state_next;
      r_col_idx <= w_col_next;
      r_settle  <= w_settle_next;
      r_db_cnt  <= w_db_next;
      r_pat     <= w_pat_next;
      r_row_s1  <= row_in;
      r_row_s2  <= r_row_s1;
    end
  end

  assign w_push  = (r_state == ST_PUSH);
  assign w_pop   = key_rd && (r_count != '0);
  // A full FIFO still accepts the push when the head is leaving in the same cycle.
  assign w_wr_en = w_push && ((r_count < NW'(DEPTH)) || w_pop);
  assign w_drop  = w_push && !w_wr_en;

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= w_code;
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop)       r_overflow <= 1'b1;
      else if (ovf_clr) r_overflow <= 1'b0;
    end
  end

  assign key_rdy    = (r_count != '0);
  assign key_code   = key_rdy ? r_mem[r_rd_ptr] : '0;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

endmodule

// File: doc/keypad_scan_buf.md
KEYPAD_SCAN_BUF -- requirements
Module: keypad_scan_buf

Interface
REQ-001 SHALL have parameter ROWS, default 4: number of keypad rows, range 2..8.
REQ-002 SHALL have parameter COLS, default 4: number of keypad columns, range 2..8.
REQ-003 SHALL have parameter SETTLE, default 2: cycles a column is driven before its rows are sampled, at least 1.
REQ-004 SHALL have parameter DEBOUNCE, default 10: consecutive stable cycles needed to accept a press or a release, range 1..255.
REQ-005 SHALL have parameter DEPTH, default 4: key FIFO entries, a power of 2, at least 2.
REQ-006 SHALL define localparam CW = $clog2(ROWS*COLS).
REQ-007 clk  in  1  rising-edge clock.
REQ-008 nRST  in  1  reset, asynchronous, active-low.
REQ-009 row_in  in  ROWS  keypad rows, pulled up; 0 means pressed.
REQ-010 col_out  out  COLS  column drive; exactly one bit is 0 and all others are 1.
REQ-011 key_rdy  out  1  FIFO non-empty.
REQ-012 key_rd  in  1  pop request from the controller.
REQ-013 key_code  out  CW  FIFO head code; 0 when empty.
REQ-014 fifo_count  out  $clog2(DEPTH)+1  number of entries held.
REQ-015 overflow  out  1  sticky flag: a key was dropped.
REQ-016 ovf_clr  in  1  synchronous clear of overflow.

Function
REQ-017 SHALL implement a scan FSM with states SCAN, DEBOUNCE, PUSH, RELEASE; col_idx selects the driven column.
REQ-018 SCAN:
- drive col_idx low for SETTLE cycles, then sample row_in;
- any row low -> DEBOUNCE, latching the sampled row pattern;
- otherwise col_idx advances, wrapping from COLS-1 to 0, and the settle counter restarts.
REQ-019 DEBOUNCE:
- col_idx is held;
- the counter increments each cycle row_in equals the latched pattern;
- any mismatch -> SCAN at the same col_idx with the counter cleared;
- counter reaching DEBOUNCE -> PUSH.
REQ-020 PUSH is one cycle:
- code = r*COLS + col_idx, where r is the lowest-index low row of the latched pattern;
- multi-row presses resolve to the lowest row;
- next state is RELEASE.
REQ-021 RELEASE:
- col_idx is held;
- row_in all 1 for DEBOUNCE consecutive cycles -> SCAN with col_idx+1 (wrapping);
- any low sample restarts the count;
- a held key produces exactly one push, with no auto-repeat.
REQ-022 FIFO is first-word-fall-through: key_code shows the oldest entry the cycle after its write; key_rdy = (fifo_count != 0).
REQ-023 Pop occurs at the clock edge where key_rd=1 and key_rdy=1; key_rd while empty is ignored with no state change.
REQ-024 Push in PUSH:
- accepted if fifo_count < DEPTH, or if a pop occurs in the same cycle;
- otherwise the code is dropped, overflow is set to 1, and FIFO contents are unchanged.
REQ-025 Simultaneous push and pop: fifo_count is unchanged, the head advances, and the new code is written at the tail.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH; fifo_count SHALL never exceed DEPTH or underflow below 0.
REQ-027 ovf_clr=1 clears overflow at the next edge; if a drop occurs in the same cycle, set wins.
REQ-028 row_in SHALL pass through a 2-flop synchronizer before use; its latency is included in all timing.

Reset
REQ-029 While nRST=0:
- state=SCAN, col_idx=0, col_out={all 1 except bit0=0};
- all counters are 0;
- FIFO is empty: key_rdy=0, key_code=0, fifo_count=0;
- overflow=0.
REQ-030 Reset asserted mid-DEBOUNCE, PUSH or RELEASE SHALL discard pending and stored keys; after deassertion scanning restarts at column 0.

Verification
REQ-031 Defaults apply; row_in[2] held low while column 1 is driven:
- key_code=9, key_rdy=1, fifo_count=1;
- key_rdy rises no later than COLS*(SETTLE+1)+DEBOUNCE+6 cycles after the press;
- a key_rd pulse -> key_rdy=0, key_code=0.
REQ-032 row_in[0] toggling every 4 cycles for 60 cycles at column 3 -> no push; fifo_count stays 0.
REQ-033 Five distinct keys pressed and released with no key_rd, codes 0,5,10,15,3:
- fifo_count=4, overflow=1;
- pops return 0,5,10,15 in that order.
REQ-034 FIFO full, key_rd=1 coinciding with a PUSH of code 7:
- fifo_count stays 4, overflow stays 0;
- code 7 is read last.
REQ-035 Key held for 500 cycles -> exactly one entry; a second press after release -> a second entry.
REQ-036 nRST pulsed low during DEBOUNCE, with 2 entries queued -> key_rdy=0, fifo_count=0, col_out=4'b1110 immediately.
